// File: rtl/fpga_rst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_rst_sequencer_pkg
// Description : Shared FPGA specification package. Holds device and family
//               enumerations, family lookups, the ns-to-cycle helper and the
//               reset sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_rst_sequencer_pkg;

  typedef enum logic [3:0] {
    MM_FPGA_XILINX_XC7A50T_11  = 4'd0,
    MM_FPGA_XILINX_XC7K325T_2  = 4'd1,
    MM_FPGA_XILINX_XCKU040_2   = 4'd2,
    MM_FPGA_XILINX_XCVU9P_22L  = 4'd3,
    MM_FPGA_INTEL_10AX115_2    = 4'd4,
    MM_FPGA_MICROSEMI_M2GL005  = 4'd5
  } mm_fpga_target_t;

  typedef enum logic [2:0] {
    MM_FAM_7SERIES     = 3'd0,
    MM_FAM_ULTRASCALE  = 3'd1,
    MM_FAM_ULTRASCALEP = 3'd2,
    MM_FAM_ARRIA10     = 3'd3,
    MM_FAM_IGLOO2      = 3'd4
  } mm_fpga_family_t;

  // Encoding is exported on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_PLL_WAIT  = 3'd1,
    S_GT_SETTLE = 3'd2,
    S_GT_WAIT   = 3'd3,
    S_USER_REL  = 3'd4,
    S_RUN       = 3'd5
  } mm_rst_seq_state_t;

  function automatic mm_fpga_family_t mm_get_fpga_family(input mm_fpga_target_t target);
    mm_fpga_family_t fam;
    case (target)
      MM_FPGA_XILINX_XC7A50T_11: fam = MM_FAM_7SERIES;
      MM_FPGA_XILINX_XC7K325T_2: fam = MM_FAM_7SERIES;
      MM_FPGA_XILINX_XCKU040_2:  fam = MM_FAM_ULTRASCALE;
      MM_FPGA_XILINX_XCVU9P_22L: fam = MM_FAM_ULTRASCALEP;
      MM_FPGA_INTEL_10AX115_2:   fam = MM_FAM_ARRIA10;
      MM_FPGA_MICROSEMI_M2GL005: fam = MM_FAM_IGLOO2;
      default:                   fam = MM_FAM_ULTRASCALEP;
    endcase
    return fam;
  endfunction

  // Transceiver settle time after PLL lock; zero for families without GTs.
  function automatic int unsigned mm_get_gt_settle_ns(input mm_fpga_family_t fam);
    int unsigned ns;
    case (fam)
      MM_FAM_7SERIES:     ns = 500;
      MM_FAM_ULTRASCALE:  ns = 1000;
      MM_FAM_ULTRASCALEP: ns = 1000;
      MM_FAM_ARRIA10:     ns = 2000;
      default:            ns = 0;
    endcase
    return ns;
  endfunction

  function automatic bit mm_family_has_gt(input mm_fpga_family_t fam);
    return (fam != MM_FAM_IGLOO2);
  endfunction

  // Rounds up so a hold time is never shortened by truncation.
  function automatic int unsigned mm_ns_to_cycles(input int unsigned ns,
                                                   input int unsigned clk_mhz);
    return (ns * clk_mhz + 32'd999) / 32'd1000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm_rst_timer.sv
`default_nettype none
// ============================================================================
// Module      : mm_rst_timer
// Description : Loadable interval timer shared by all timed sequencer states.
//               Reloaded on state entry; expired_o flags the last cycle of the
//               programmed interval (limit_i cycles after the reload).
// Revision    : 1.0 - initial release
// ============================================================================
module mm_rst_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;

  // Elapsed-cycle count since the last reload, saturating so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign expired_o = (cnt_q == (limit_i - WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/fpga_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpga_rst_sequencer
// Description : Power-up / recovery reset sequencer. Resets the PLL, waits
//               for lock, runs the transceiver reset handshake, then releases
//               user logic. Timeouts re-enter the sequence and are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_rst_sequencer
  import fpga_rst_sequencer_pkg::*;
#(
  parameter mm_fpga_target_t FPGA_TARGET     = MM_FPGA_XILINX_XCVU9P_22L,
  parameter int unsigned     CLK_FREQ_MHZ    = 125,
  parameter int unsigned     LOCK_TIMEOUT_US = 1000,
  parameter int unsigned     USER_HOLD_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked_i,
  input  logic       gt_reset_done_i,
  output logic       pll_rst_o,
  output logic       gt_rst_o,
  output logic       user_rst_o,
  output logic       done_o,
  output logic       fault_o,
  output logic [7:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam mm_fpga_family_t FAMILY = mm_get_fpga_family(FPGA_TARGET);
  localparam bit HAS_GT = mm_family_has_gt(FAMILY);
  localparam int unsigned PLL_RST_CYC = mm_ns_to_cycles(1000, CLK_FREQ_MHZ);
  // Families without a GT stage never visit S_GT_SETTLE; 1 keeps the timer limit sane.
  localparam int unsigned GT_SETTLE_CYC =
      HAS_GT ? mm_ns_to_cycles(mm_get_gt_settle_ns(FAMILY), CLK_FREQ_MHZ) : 1;
  localparam int unsigned TIMEOUT_CYC = LOCK_TIMEOUT_US * CLK_FREQ_MHZ;
  localparam int unsigned MAX_A = (TIMEOUT_CYC > GT_SETTLE_CYC) ? TIMEOUT_CYC : GT_SETTLE_CYC;
  localparam int unsigned MAX_B = (MAX_A > PLL_RST_CYC) ? MAX_A : PLL_RST_CYC;
  // The user hold interval runs on the same timer, so it must fit as well.
  localparam int unsigned MAX_CYC = (MAX_B > USER_HOLD_CYC) ? MAX_B : USER_HOLD_CYC;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  mm_rst_seq_state_t state_q, state_d;
  logic              timeout;
  logic              tmr_expired;
  logic [CNT_W-1:0]  tmr_limit;

  logic       pll_rst_q, gt_rst_q, user_rst_q, done_q, fault_q;
  logic [7:0] retry_q, retry_d;
  logic [2:0] state_out_q;

  mm_rst_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (state_d != state_q),
    .limit_i   (tmr_limit),
    .expired_o (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PLL_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, timer interval selection and timeout detection.
  always_comb begin
    state_d   = state_q;
    timeout   = 1'b0;
    tmr_limit = CNT_W'(TIMEOUT_CYC);
    unique case (state_q)
      S_PLL_RST: begin
        tmr_limit = CNT_W'(PLL_RST_CYC);
        if (tmr_expired) state_d = S_PLL_WAIT;
      end
      S_PLL_WAIT: begin
        if (pll_locked_i) begin
          state_d = HAS_GT ? S_GT_SETTLE : S_USER_REL;
        end else if (tmr_expired) begin
          state_d = S_PLL_RST;
          timeout = 1'b1;
        end
      end
      S_GT_SETTLE: begin
        tmr_limit = CNT_W'(GT_SETTLE_CYC);
        if (!pll_locked_i)    state_d = S_PLL_RST;
        else if (tmr_expired) state_d = S_GT_WAIT;
      end
      S_GT_WAIT: begin
        // A timeout coinciding with lock loss is still counted as a fault.
        if (!gt_reset_done_i && tmr_expired) begin
          state_d = S_PLL_RST;
          timeout = 1'b1;
        end else if (!pll_locked_i) begin
          state_d = S_PLL_RST;
        end else if (gt_reset_done_i) begin
          state_d = S_USER_REL;
        end
      end
      S_USER_REL: begin
        tmr_limit = CNT_W'(USER_HOLD_CYC);
        if (!pll_locked_i)    state_d = S_PLL_RST;
        else if (tmr_expired) state_d = S_RUN;
      end
      S_RUN: begin
        if (!pll_locked_i) state_d = S_PLL_RST;
      end
      default: state_d = S_PLL_RST;
    endcase
  end

  assign retry_d = (timeout && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;

  // Registered Moore outputs decoded from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pll_rst_q   <= 1'b1;
      gt_rst_q    <= 1'b1;
      user_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= 8'd0;
      state_out_q <= 3'd0;
    end else begin
      pll_rst_q   <= (state_q == S_PLL_RST);
      gt_rst_q    <= !HAS_GT || (state_q inside {S_PLL_RST, S_PLL_WAIT, S_GT_SETTLE});
      user_rst_q  <= (state_q != S_RUN);
      done_q      <= (state_q == S_RUN);
      fault_q     <= timeout;
      retry_q     <= retry_d;
      state_out_q <= state_q;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign gt_rst_o    = gt_rst_q;
  assign user_rst_o  = user_rst_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_rst_sequencer
// Description : Self-checking bench for fpga_rst_sequencer. Several device
//               configurations run side by side; a small-constant instance
//               takes a vector table, randomized traffic against a reference
//               model, and a retry-counter saturation run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_rst_sequencer;
  import fpga_rst_sequencer_pkg::*;

  // Small instance (index 4): 8 MHz, 2 us timeout, 4-cycle user hold.
  localparam int SM_P = (1000 * 8 + 999) / 1000;  // PLL reset cycles
  localparam int SM_G = (1000 * 8 + 999) / 1000;  // UltraScale+ GT settle
  localparam int SM_T = 2 * 8;                    // timeout cycles
  localparam int SM_H = 4;                        // user hold cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_main, rst_sm;
  logic       lk     [5];
  logic       gd     [5];
  logic       o_pll  [5];
  logic       o_gt   [5];
  logic       o_user [5];
  logic       o_done [5];
  logic       o_fault[5];
  logic [7:0] o_retry[5];
  logic [2:0] o_state[5];

  int n_chk  = 0;
  int n_fail = 0;

  fpga_rst_sequencer u_vu9p (
    .clk(clk), .rst(rst_main), .pll_locked_i(lk[0]), .gt_reset_done_i(gd[0]),
    .pll_rst_o(o_pll[0]), .gt_rst_o(o_gt[0]), .user_rst_o(o_user[0]), .done_o(o_done[0]),
    .fault_o(o_fault[0]), .retry_cnt_o(o_retry[0]), .state_o(o_state[0]));

  fpga_rst_sequencer #(.FPGA_TARGET(MM_FPGA_XILINX_XC7A50T_11)) u_a7 (
    .clk(clk), .rst(rst_main), .pll_locked_i(lk[1]), .gt_reset_done_i(gd[1]),
    .pll_rst_o(o_pll[1]), .gt_rst_o(o_gt[1]), .user_rst_o(o_user[1]), .done_o(o_done[1]),
    .fault_o(o_fault[1]), .retry_cnt_o(o_retry[1]), .state_o(o_state[1]));

  fpga_rst_sequencer #(.FPGA_TARGET(MM_FPGA_MICROSEMI_M2GL005)) u_igl (
    .clk(clk), .rst(rst_main), .pll_locked_i(lk[2]), .gt_reset_done_i(gd[2]),
    .pll_rst_o(o_pll[2]), .gt_rst_o(o_gt[2]), .user_rst_o(o_user[2]), .done_o(o_done[2]),
    .fault_o(o_fault[2]), .retry_cnt_o(o_retry[2]), .state_o(o_state[2]));

  fpga_rst_sequencer #(.LOCK_TIMEOUT_US(1)) u_to (
    .clk(clk), .rst(rst_main), .pll_locked_i(lk[3]), .gt_reset_done_i(gd[3]),
    .pll_rst_o(o_pll[3]), .gt_rst_o(o_gt[3]), .user_rst_o(o_user[3]), .done_o(o_done[3]),
    .fault_o(o_fault[3]), .retry_cnt_o(o_retry[3]), .state_o(o_state[3]));

  fpga_rst_sequencer #(.CLK_FREQ_MHZ(8), .LOCK_TIMEOUT_US(2), .USER_HOLD_CYC(4)) u_sm (
    .clk(clk), .rst(rst_sm), .pll_locked_i(lk[4]), .gt_reset_done_i(gd[4]),
    .pll_rst_o(o_pll[4]), .gt_rst_o(o_gt[4]), .user_rst_o(o_user[4]), .done_o(o_done[4]),
    .fault_o(o_fault[4]), .retry_cnt_o(o_retry[4]), .state_o(o_state[4]));

  typedef struct {
    bit r, l, g;
    int n;
    bit e_pll, e_gt, e_user, e_done, e_fault;
    int e_st, e_retry;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit r, l, g, input int n,
                         input bit ep, eg, eu, ed, ef, input int es, er);
    vec_t v;
    v.r = r; v.l = l; v.g = g; v.n = n;
    v.e_pll = ep; v.e_gt = eg; v.e_user = eu; v.e_done = ed; v.e_fault = ef;
    v.e_st = es; v.e_retry = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: phase index plus cycles spent in that phase.
  int m_state, m_age, m_retry;

  task automatic model_edge(input bit r, l, g, output logic [14:0] e);
    int  s, nxt;
    bit  to;
    if (r) begin
      m_state = 0; m_age = 0; m_retry = 0;
      e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      return;
    end
    s = m_state; nxt = s; to = 1'b0;
    case (s)
      0: if (m_age + 1 >= SM_P) nxt = 1;
      1: if (l) nxt = 2; else if (m_age + 1 >= SM_T) begin nxt = 0; to = 1'b1; end
      2: if (!l) nxt = 0; else if (m_age + 1 >= SM_G) nxt = 3;
      3: if (!g && m_age + 1 >= SM_T) begin nxt = 0; to = 1'b1; end
         else if (!l) nxt = 0;
         else if (g) nxt = 4;
      4: if (!l) nxt = 0; else if (m_age + 1 >= SM_H) nxt = 5;
      default: if (!l) nxt = 0;
    endcase
    if (to && m_retry < 255) m_retry++;
    e = {s == 0, s <= 2, s != 5, s == 5, to, 3'(s), 8'(m_retry)};
    m_age   = (nxt == s) ? m_age + 1 : 0;
    m_state = nxt;
  endtask

  initial begin
    int f_pll0, f_gt0, st2_0, f_done0, f_redone0;
    int st2_1, f_done1, f_done2, gt_low2, nf3, code;
    int seq2[$];

    // ---------------- Vector table for the small instance ----------------
    //       r  l  g  n    pll gt user done fault st retry
    add_vec(1, 1, 1, 2,   1, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 8,   1, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 1,   0, 1, 1, 0, 0, 1, 0);
    add_vec(0, 1, 1, 1,   0, 1, 1, 0, 0, 2, 0);
    add_vec(0, 1, 1, 7,   0, 1, 1, 0, 0, 2, 0);
    add_vec(0, 1, 1, 1,   0, 0, 1, 0, 0, 3, 0);
    add_vec(0, 1, 1, 1,   0, 0, 1, 0, 0, 4, 0);
    add_vec(0, 1, 1, 3,   0, 0, 1, 0, 0, 4, 0);
    add_vec(0, 1, 1, 1,   0, 0, 0, 1, 0, 5, 0);
    add_vec(0, 0, 1, 1,   0, 0, 0, 1, 0, 5, 0);
    add_vec(0, 1, 1, 1,   1, 1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 1, 23,  0, 1, 1, 0, 1, 1, 1);
    add_vec(0, 0, 1, 1,   1, 1, 1, 0, 0, 0, 1);
    add_vec(0, 1, 0, 31,  0, 0, 1, 0, 0, 3, 1);
    add_vec(0, 0, 0, 1,   0, 0, 1, 0, 1, 3, 2);
    add_vec(0, 1, 1, 1,   1, 1, 1, 0, 0, 0, 2);
    add_vec(0, 1, 0, 18,  0, 0, 1, 0, 0, 3, 2);
    add_vec(1, 1, 0, 1,   1, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 22,  0, 0, 1, 0, 0, 4, 0);
    add_vec(0, 1, 1, 1,   0, 0, 0, 1, 0, 5, 0);
    add_vec(0, 1, 0, 5,   0, 0, 0, 1, 0, 5, 0);
    add_vec(0, 0, 0, 1,   0, 0, 0, 1, 0, 5, 0);
    add_vec(0, 1, 0, 1,   1, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 0, 19,  0, 0, 1, 0, 0, 3, 0);
    add_vec(0, 0, 0, 1,   0, 0, 1, 0, 0, 3, 0);
    add_vec(0, 1, 1, 1,   1, 1, 1, 0, 0, 0, 0);

    // ---------------- Phase 1: device configurations in parallel ----------
    rst_main = 1'b1; rst_sm = 1'b1;
    for (int i = 0; i < 5; i++) begin lk[i] = 1'b1; gd[i] = 1'b1; end
    lk[3] = 1'b0;
    step(3);
    check("rst_pll",   o_pll[0],   1);
    check("rst_gt",    o_gt[0],    1);
    check("rst_user",  o_user[0],  1);
    check("rst_done",  o_done[0],  0);
    check("rst_fault", o_fault[0], 0);
    check("rst_retry", o_retry[0], 0);
    check("rst_state", o_state[0], 0);

    rst_main = 1'b0;  // this cycle is cycle 0
    f_pll0 = -1; f_gt0 = -1; st2_0 = 0; f_done0 = -1; f_redone0 = -1;
    st2_1 = 0; f_done1 = -1; f_done2 = -1; gt_low2 = 0; nf3 = 0;
    seq2.push_back(int'(o_state[2]));
    for (int c = 1; c <= 800; c++) begin
      step(1);
      if (!o_pll[0] && f_pll0 < 0) f_pll0 = c;
      if (!o_gt[0] && f_gt0 < 0) f_gt0 = c;
      if (c < 300 && o_state[0] == 3'd2) st2_0++;
      if (c < 300 && o_done[0] && f_done0 < 0) f_done0 = c;
      if (c == 301) check("vu9p_done_before_loss", o_done[0], 1);
      if (c == 302) begin
        check("vu9p_loss_done",  o_done[0],  0);
        check("vu9p_loss_user",  o_user[0],  1);
        check("vu9p_loss_state", o_state[0], 0);
        check("vu9p_loss_retry", o_retry[0], 0);
        check("vu9p_loss_fault", o_fault[0], 0);
      end
      if (c > 302 && o_done[0] && f_redone0 < 0) f_redone0 = c;
      if (o_state[1] == 3'd2) st2_1++;
      if (o_done[1] && f_done1 < 0) f_done1 = c;
      if (int'(o_state[2]) != seq2[$]) seq2.push_back(int'(o_state[2]));
      if (!o_gt[2]) gt_low2++;
      if (o_done[2] && f_done2 < 0) f_done2 = c;
      if (o_fault[3]) begin
        nf3++;
        check($sformatf("to_fault%0d_cycle", nf3), c, 250 * nf3);
        check($sformatf("to_fault%0d_retry", nf3), o_retry[3], nf3);
      end
      // Lock glitch of one cycle while the XCVU9P instance is running.
      if (c == 300) lk[0] = 1'b0;
      if (c == 301) lk[0] = 1'b1;
    end
    check("vu9p_pll_rst_release", f_pll0, 126);
    check("vu9p_gt_rst_release", f_gt0, 252);
    check("vu9p_gt_settle_len", st2_0, 125);
    check("vu9p_done_cycle", f_done0, 269);
    check("vu9p_redone_cycle", f_redone0, 570);
    check("a7_gt_settle_len", st2_1, 63);
    check("a7_done_cycle", f_done1, 207);
    code = 0;
    foreach (seq2[i]) code = code * 10 + seq2[i];
    check("igl_seq_len", seq2.size(), 4);
    check("igl_seq", code, 145);
    check("igl_gt_low_cycles", gt_low2, 0);
    check("igl_done_cycle", f_done2, 143);
    check("to_fault_count", nf3, 3);

    // ---------------- Phase 2: vector table on the small instance --------
    foreach (vecs[i]) begin
      rst_sm = vecs[i].r; lk[4] = vecs[i].l; gd[4] = vecs[i].g;
      step(vecs[i].n);
      check($sformatf("vec%0d_pll", i),   o_pll[4],   vecs[i].e_pll);
      check($sformatf("vec%0d_gt", i),    o_gt[4],    vecs[i].e_gt);
      check($sformatf("vec%0d_user", i),  o_user[4],  vecs[i].e_user);
      check($sformatf("vec%0d_done", i),  o_done[4],  vecs[i].e_done);
      check($sformatf("vec%0d_fault", i), o_fault[4], vecs[i].e_fault);
      check($sformatf("vec%0d_state", i), o_state[4], vecs[i].e_st);
      check($sformatf("vec%0d_retry", i), o_retry[4], vecs[i].e_retry);
    end

    // ---------------- Phase 3: randomized traffic vs model ---------------
    begin
      logic [14:0] exp_v, got_v;
      int lb, gb;
      bit r, l, g;
      rst_sm = 1'b1;
      step(1);
      model_edge(1'b1, 1'b1, 1'b1, exp_v);
      lb = 40; gb = 4;
      for (int c = 0; c < 2000; c++) begin
        if (c % 64 == 0) begin
          lb = $urandom_range(1, 40);
          gb = $urandom_range(1, 8);
        end
        r = ($urandom_range(0, 299) == 0);
        l = ($urandom_range(0, lb - 1) != 0);
        g = ($urandom_range(0, gb - 1) != 0);
        rst_sm = r; lk[4] = l; gd[4] = g;
        step(1);
        model_edge(r, l, g, exp_v);
        got_v = {o_pll[4], o_gt[4], o_user[4], o_done[4], o_fault[4], o_state[4], o_retry[4]};
        check($sformatf("rand%0d_outputs", c), got_v, exp_v);
      end
    end

    // ---------------- Phase 4: retry counter saturation ------------------
    begin
      int nf;
      rst_sm = 1'b1; lk[4] = 1'b0; gd[4] = 1'b1;
      step(1);
      rst_sm = 1'b0;
      nf = 0;
      for (int c = 1; c <= 7210; c++) begin
        step(1);
        if (o_fault[4]) nf++;
        if (c == (SM_P + SM_T) * 10) check("sat_retry_10", o_retry[4], 10);
        if (c == (SM_P + SM_T) * 255) check("sat_retry_255", o_retry[4], 255);
      end
      check("sat_fault_count", nf, 300);
      check("sat_retry_final", o_retry[4], 255);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpga_rst_sequencer.md
# fpga_rst_sequencer

Power-up and recovery reset sequencer for a board's clocking and transceiver resources. The sequence is specialised per FPGA family, derived at elaboration from the `FPGA_TARGET` parameter. The block drives PLL/MMCM reset, waits for lock, then runs the transceiver reset handshake, then releases the user-logic reset. Loss of lock or handshake timeouts re-enter the sequence. It sits in each FPGA top level between the board reset and all clocking and transceiver wrappers.

## Interface
Parameters:
- `FPGA_TARGET`, default `MM_FPGA_XILINX_XCVU9P_22L`, type `mm_fpga_target_t`: device; family is derived via `mm_get_fpga_family`.
- `CLK_FREQ_MHZ`, default 125: `clk` frequency, used for ns→cycle conversion.
- `LOCK_TIMEOUT_US`, default 1000: timeout for each wait state.
- `USER_HOLD_CYC`, default 16: cycles `user_rst_o` is held after the GT stage completes.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset. Synchronous, active-high.
- `pll_locked_i` in 1: PLL/MMCM lock, already synchronised to `clk`.
- `gt_reset_done_i` in 1: transceiver reset-done, already synchronised.
- `pll_rst_o` out 1: PLL/MMCM reset.
- `gt_rst_o` out 1: transceiver reset.
- `user_rst_o` out 1: user-logic reset.
- `done_o` out 1: sequence complete, asserted in RUN.
- `fault_o` out 1: one-cycle pulse on a timeout.
- `retry_cnt_o` out 8: timeout count, saturates at 255.
- `state_o` out 3: current state encoding, for status registers.

## Operation
Derived constants:
- cycles(ns) = ceil(ns × `CLK_FREQ_MHZ` / 1000).
- `PLL_RST_CYC` = cycles(1000) for every family.
- `GT_SETTLE_CYC` = cycles(GT_SETTLE_NS[family]).
- GT_SETTLE_NS: 7SERIES 500, ULTRASCALE 1000, ULTRASCALEP 1000, ARRIA10 2000, IGLOO2 n/a (family has no GT stage).
- `TIMEOUT_CYC` = `LOCK_TIMEOUT_US` × `CLK_FREQ_MHZ`.

States (encoding 0–5):
- `S_PLL_RST` (0): `pll_rst_o`=1, `gt_rst_o`=1, `user_rst_o`=1. Stays exactly `PLL_RST_CYC` cycles, then goes to `S_PLL_WAIT`.
- `S_PLL_WAIT` (1): `pll_rst_o`=0.
  - `pll_locked_i`=1 → `S_GT_SETTLE`, or `S_USER_REL` for IGLOO2.
  - `TIMEOUT_CYC` cycles without lock → fault, back to `S_PLL_RST`.
- `S_GT_SETTLE` (2): `gt_rst_o`=1. Stays exactly `GT_SETTLE_CYC` cycles, then goes to `S_GT_WAIT`.
- `S_GT_WAIT` (3): `gt_rst_o`=0.
  - `gt_reset_done_i`=1 → `S_USER_REL`.
  - Timeout → fault, back to `S_PLL_RST`.
- `S_USER_REL` (4): `user_rst_o`=1 for exactly `USER_HOLD_CYC` cycles, then goes to `S_RUN`.
- `S_RUN` (5): `user_rst_o`=0, `done_o`=1.

Lock loss and recovery:
- `pll_locked_i`=0 in states 2–5 → `S_PLL_RST` on the next cycle. No fault pulse, no retry increment.
- `gt_reset_done_i` falling in `S_RUN` is ignored.

Fault accounting:
- A fault pulses `fault_o` for one cycle and increments `retry_cnt_o`, saturating at 255.

`gt_rst_o` is held at 1 permanently for IGLOO2.

## Timing
- All outputs are registered Moore outputs and change on the cycle after the state changes.
- Reset values:
  - `pll_rst_o`=1, `gt_rst_o`=1, `user_rst_o`=1.
  - `done_o`=0, `fault_o`=0, `retry_cnt_o`=0.
  - `state_o`=0, internal counter=0.
- The first counted cycle of `S_PLL_RST` is the first cycle with `rst`=0.
- `rst` mid-sequence aborts immediately to reset values, including `retry_cnt_o`.
- Lock loss and timeout in the same cycle: timeout wins, so the fault is counted.
- A counter of ceil(log2(max(`TIMEOUT_CYC`, `GT_SETTLE_CYC`, `PLL_RST_CYC`)+1)) bits is reloaded on every state entry.
- Minimum cycles from `rst` deassert to `done_o`=1, with inputs already high: `PLL_RST_CYC` + 1 + `GT_SETTLE_CYC` + 1 + `USER_HOLD_CYC` + 1. IGLOO2 omits the GT terms.

## Structure
- Add `mm_get_gt_settle_ns(mm_fpga_family_t)` and `mm_family_has_gt(mm_fpga_family_t)` to the shared FPGA spec package.
- Add a `localparam`-style ns→cycle helper function to the same package.
- State enum `mm_rst_seq_state_t` lives in the same package.
- One sub-module, `mm_rst_timer`: a loadable down-counter with an `expired` flag, shared by all timed states.

## Test plan
1. XCVU9P_22L, 125 MHz, inputs high: `pll_rst_o` high 125 cycles, `gt_rst_o` high 125 cycles in `S_GT_SETTLE`, `done_o` at cycle 125+1+125+1+16+1 = 269.
2. XC7A50T_11, 125 MHz: `S_GT_SETTLE` lasts 63 cycles (ceil of 62.5).
3. M2GL005 (IGLOO2): state sequence 0→1→4→5, `gt_rst_o` never 0, `done_o` at cycle 125+1+16+1 = 143.
4. `LOCK_TIMEOUT_US`=1, `pll_locked_i` held 0: `fault_o` pulses every 125+125 cycles, `retry_cnt_o` counts 1, 2, 3…; force 300 timeouts → saturates at 255.
5. Drop `pll_locked_i` for 1 cycle in `S_RUN`: `done_o`→0 and `user_rst_o`→1 next cycle, `state_o`=0, `retry_cnt_o` unchanged, full resequence follows.
6. Assert `rst` for 1 cycle mid-`S_GT_WAIT`: all outputs return to reset values next cycle, `retry_cnt_o`=0.
